// File: rtl/uart_servo_ctrl.sv
// uart_servo_ctrl: turns 3-byte position frames from the UART receiver into a
// servo pulse width. Each completed frame is answered with an ACK or NAK byte
// through the UART transmitter, using a one-deep response queue.
module uart_servo_ctrl #(
  parameter int unsigned PW_MIN_CYC  = 27000,
  parameter int unsigned PW_STEP_CYC = 106,
  parameter int unsigned WIDTH_W     = 17,
  parameter int unsigned TIMEOUT_CYC = 2700000,
  parameter logic [7:0]  SYNC_BYTE   = 8'h55,
  parameter logic [7:0]  ACK_BYTE    = 8'h06,
  parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               rx_break,
  input  logic               tx_busy,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  output logic [WIDTH_W-1:0] pwm_width,
  output logic               pwm_update,
  output logic               frame_ok,
  output logic               frame_err
);

  // Largest value pwm_width can hold; wider results saturate to this.
  localparam logic [40:0] WMAX = (WIDTH_W >= 41) ? {41{1'b1}}
                                                 : ((41'd1 << WIDTH_W) - 41'd1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  // Position-to-width mapping at full precision, saturating on overflow.
  function automatic logic [WIDTH_W-1:0] calc_width(input logic [7:0] pos);
    logic [40:0] full;
    full = 41'(PW_MIN_CYC) + 41'(PW_STEP_CYC) * 41'(pos);
    if (full > WMAX) begin
      return '1;
    end
    return full[WIDTH_W-1:0];
  endfunction

  localparam logic [WIDTH_W-1:0] PW_CENTRE = calc_width(8'd128);

  typedef enum logic [1:0] {P_IDLE, P_POS, P_CHK} pstate_e;
  typedef enum logic [1:0] {T_IDLE, T_HOLD, T_WAIT} tstate_e;

  pstate_e            p_q, p_d;
  tstate_e            t_q, t_d;
  logic [7:0]         pos_q, pos_d;
  logic [31:0]        tmo_q, tmo_d;
  logic [WIDTH_W-1:0] pwm_q, pwm_d;
  logic               upd_q, upd_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic               pend_q, pend_d;
  logic [7:0]         pend_byte_q, pend_byte_d;
  logic               hold_q, hold_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         tx_data_q, tx_data_d;

  logic               resp_valid;
  logic [7:0]         resp_byte;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_q         <= P_IDLE;
      t_q         <= T_IDLE;
      pos_q       <= 8'h00;
      tmo_q       <= 32'd0;
      pwm_q       <= PW_CENTRE;
      upd_q       <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_byte_q <= ACK_BYTE;
      hold_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= ACK_BYTE;
    end else begin
      p_q         <= p_d;
      t_q         <= t_d;
      pos_q       <= pos_d;
      tmo_q       <= tmo_d;
      pwm_q       <= pwm_d;
      upd_q       <= upd_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      hold_q      <= hold_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
    end
  end

  // Frame parser: break beats a byte, a byte beats the timeout expiry.
  always_comb begin
    p_d        = p_q;
    pos_d      = pos_q;
    tmo_d      = 32'd0;
    pwm_d      = pwm_q;
    upd_d      = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    resp_valid = 1'b0;
    resp_byte  = ACK_BYTE;
    case (p_q)
      P_IDLE: begin
        if (rx_valid && !rx_break && (rx_data == SYNC_BYTE)) begin
          p_d = P_POS;
        end
      end
      P_POS, P_CHK: begin
        if (rx_break) begin
          p_d   = P_IDLE;
          err_d = 1'b1;
        end else if (rx_valid) begin
          if (p_q == P_POS) begin
            pos_d = rx_data;
            p_d   = P_CHK;
          end else begin
            p_d        = P_IDLE;
            resp_valid = 1'b1;
            if (rx_data == ~pos_q) begin
              pwm_d     = calc_width(pos_q);
              upd_d     = 1'b1;
              ok_d      = 1'b1;
              resp_byte = ACK_BYTE;
            end else begin
              err_d     = 1'b1;
              resp_byte = NAK_BYTE;
            end
          end
        end else if (tmo_q >= TMO_LAST) begin
          p_d   = P_IDLE;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: p_d = P_IDLE;
    endcase
  end

  // Response queue and transmit handshake; a new response overwrites a
  // pending one, but a byte already loaded into tx_data is left alone.
  always_comb begin
    t_d         = t_q;
    hold_d      = hold_q;
    tx_en_d     = 1'b0;
    tx_data_d   = tx_data_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    case (t_q)
      T_IDLE: begin
        if (pend_q && !tx_busy) begin
          tx_en_d   = 1'b1;
          tx_data_d = pend_byte_q;
          pend_d    = 1'b0;
          hold_d    = 1'b0;
          t_d       = T_HOLD;
        end
      end
      T_HOLD: begin
        if (hold_q) begin
          t_d = T_WAIT;
        end else begin
          hold_d = 1'b1;
        end
      end
      T_WAIT: begin
        if (!tx_busy) begin
          t_d = T_IDLE;
        end
      end
      default: t_d = T_IDLE;
    endcase
    if (resp_valid) begin
      pend_d      = 1'b1;
      pend_byte_d = resp_byte;
    end
  end

  assign tx_en      = tx_en_q;
  assign tx_data    = tx_data_q;
  assign pwm_width  = pwm_q;
  assign pwm_update = upd_q;
  assign frame_ok   = ok_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_uart_servo_ctrl.sv
// tb_uart_servo_ctrl: directed frames with hand-computed widths and responses.
module tb_uart_servo_ctrl;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_break;
  logic        tx_busy;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [16:0] pwm_width;
  logic        pwm_update;
  logic        frame_ok;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int txCount = 0;
  int okCount = 0;
  int errCount = 0;
  int updCount = 0;

  uart_servo_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data),
    .pwm_width(pwm_width), .pwm_update(pwm_update), .frame_ok(frame_ok),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (tx_en) txCount++;
    if (frame_ok) okCount++;
    if (frame_err) errCount++;
    if (pwm_update) updCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0; tx_busy = 1'b0;
    idle(3);
    checkOutput("rst_pwm", 32'(pwm_width), 40568);
    checkOutput("rst_txdata", 32'(tx_data), 32'h06);
    checkOutput("rst_txen", 32'(tx_en), 0);
    checkOutput("rst_ok", 32'(frame_ok), 0);
    resetn = 1'b1;
    idle(100);
    #1;
    checkOutput("idle_txcount", txCount, 0);
    checkOutput("idle_pwm", 32'(pwm_width), 40568);
    @(negedge clk);

    // Minimum position with exact response timing.
    applyStimulus(8'h55); applyStimulus(8'h00); applyStimulus(8'hFF);
    checkOutput("f1_ok", 32'(frame_ok), 1);
    checkOutput("f1_upd", 32'(pwm_update), 1);
    checkOutput("f1_pwm", 32'(pwm_width), 27000);
    checkOutput("f1_txen_early", 32'(tx_en), 0);
    @(negedge clk);
    checkOutput("f1_txen", 32'(tx_en), 1);
    checkOutput("f1_txdata", 32'(tx_data), 32'h06);
    checkOutput("f1_ok_single", 32'(frame_ok), 0);
    idle(6);

    // Maximum position.
    applyStimulus(8'h55); applyStimulus(8'hFF); applyStimulus(8'h00);
    idle(6);
    #1;
    checkOutput("f2_pwm", 32'(pwm_width), 54030);
    checkOutput("f2_txcount", txCount, 2);
    checkOutput("f2_updcount", updCount, 2);
    @(negedge clk);

    // Bad checksum answers NAK and keeps the width.
    applyStimulus(8'h55); applyStimulus(8'h10); applyStimulus(8'h10);
    checkOutput("bad_err", 32'(frame_err), 1);
    idle(6);
    #1;
    checkOutput("bad_pwm", 32'(pwm_width), 54030);
    checkOutput("bad_txdata", 32'(tx_data), 32'h15);
    checkOutput("bad_txcount", txCount, 3);
    @(negedge clk);

    // Inter-byte timeout expires on the TMO-th idle cycle.
    applyStimulus(8'h55); applyStimulus(8'h40);
    idle(TMO - 1);
    checkOutput("tmo_not_yet", 32'(frame_err), 0);
    @(negedge clk);
    checkOutput("tmo_err", 32'(frame_err), 1);
    applyStimulus(8'hBF);
    idle(5);
    #1;
    checkOutput("tmo_okcount", okCount, 2);
    checkOutput("tmo_txcount", txCount, 3);
    @(negedge clk);

    // A byte arriving in the expiry cycle wins over the timeout.
    applyStimulus(8'h55); applyStimulus(8'h40);
    idle(TMO - 1);
    applyStimulus(8'hBF);
    checkOutput("edge_ok", 32'(frame_ok), 1);
    checkOutput("edge_pwm", 32'(pwm_width), 33784);
    idle(6);

    // Two frames while the first response is in flight: the last one wins.
    applyStimulus(8'h55); applyStimulus(8'h20); applyStimulus(8'hDF);
    @(negedge clk);
    checkOutput("q_txen", 32'(tx_en), 1);
    tx_busy = 1'b1;
    @(negedge clk);
    applyStimulus(8'h55); applyStimulus(8'h30); applyStimulus(8'hCF);
    applyStimulus(8'h55); applyStimulus(8'h10); applyStimulus(8'h10);
    idle(6);
    #1;
    checkOutput("q_txcount_busy", txCount, 5);
    checkOutput("q_txdata_held", 32'(tx_data), 32'h06);
    @(negedge clk);
    tx_busy = 1'b0;
    idle(8);
    #1;
    checkOutput("q_txcount", txCount, 6);
    checkOutput("q_txdata_last", 32'(tx_data), 32'h15);
    checkOutput("q_pwm", 32'(pwm_width), 32088);
    @(negedge clk);

    // Break in the same cycle as a valid checksum byte aborts the frame.
    applyStimulus(8'h55); applyStimulus(8'h20);
    rx_break = 1'b1;
    applyStimulus(8'hDF);
    rx_break = 1'b0;
    idle(4);
    // Bytes received during a break in idle are dropped.
    rx_break = 1'b1;
    applyStimulus(8'h55);
    rx_break = 1'b0;
    applyStimulus(8'h40); applyStimulus(8'hBF);
    idle(6);
    #1;
    checkOutput("brk_errcount", errCount, 4);
    checkOutput("brk_okcount", okCount, 5);
    checkOutput("brk_pwm", 32'(pwm_width), 32088);
    checkOutput("brk_txcount", txCount, 6);
    @(negedge clk);

    // Asynchronous reset while waiting on the transmitter with a response pending.
    applyStimulus(8'h55); applyStimulus(8'h10); applyStimulus(8'h10);
    @(negedge clk);
    tx_busy = 1'b1;
    idle(3);
    applyStimulus(8'h55); applyStimulus(8'h00); applyStimulus(8'hFF);
    idle(2);
    checkOutput("pre_rst_txdata", 32'(tx_data), 32'h15);
    #2 resetn = 1'b0;
    #1;
    checkOutput("arst_pwm", 32'(pwm_width), 40568);
    checkOutput("arst_txdata", 32'(tx_data), 32'h06);
    checkOutput("arst_txen", 32'(tx_en), 0);
    checkOutput("arst_ok", 32'(frame_ok), 0);
    idle(2);
    resetn = 1'b1;
    tx_busy = 1'b0;
    idle(10);
    #1;
    checkOutput("arst_drop_pend", txCount, 7);
    checkOutput("arst_pwm_after", 32'(pwm_width), 40568);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_servo_ctrl.md
# uart_servo_ctrl

Command controller between the UART receiver, the UART transmitter and the servo PWM generator. Parses 3-byte position frames from the `uart_rx` byte stream and validates them with a checksum. Converts the position byte into a PWM pulse width in clock cycles for `servo_control`, and answers every completed frame with an ACK or NAK byte through `uart_tx` using a one-deep response queue.

## Interface
Parameters:
- `PW_MIN_CYC`, 27000: pulse width for position 0, in clk cycles (1.0 ms at 27 MHz).
- `PW_STEP_CYC`, 106: pulse-width increment per position LSB.
- `WIDTH_W`, 17: width of `pwm_width`.
- `TIMEOUT_CYC`, 2700000: maximum idle cycles between bytes inside a frame (100 ms).
- `SYNC_BYTE`, 8'h55: frame header.
- `ACK_BYTE`, 8'h06: positive response.
- `NAK_BYTE`, 8'h15: negative response.

Ports:
- `clk`  in  1  system clock; one clock, all logic on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a new byte.
- `rx_data`  in  8  received byte.
- `rx_break`  in  1  line break detected; level.
- `tx_busy`  in  1  transmitter busy.
- `tx_en`  out  1  one-cycle transmit request.
- `tx_data`  out  8  byte to transmit; held stable from the `tx_en` cycle until `tx_busy` falls.
- `pwm_width`  out  WIDTH_W  pulse width to the servo generator.
- `pwm_update`  out  1  one-cycle strobe when `pwm_width` changes.
- `frame_ok`  out  1  one-cycle strobe on an accepted frame.
- `frame_err`  out  1  one-cycle strobe on a bad checksum, timeout or break abort.

## Operation
- Frame format: `SYNC_BYTE`, then `POS`, then `CHK`. The frame is valid when `CHK == ~POS`.
- Parser FSM:
  - `P_IDLE`: a byte equal to `SYNC_BYTE` moves to `P_POS`. Any other byte is discarded silently.
  - `P_POS`: store `POS`, move to `P_CHK`. A `POS` of 8'h55 is data, not a resync.
  - `P_CHK`:
    - Checksum good: `pwm_width <= PW_MIN_CYC + POS*PW_STEP_CYC`, pulse `pwm_update` and `frame_ok`, queue `ACK_BYTE`.
    - Checksum bad: `pwm_width` unchanged, pulse `frame_err`, queue `NAK_BYTE`.
    - Either way, return to `P_IDLE`.
- Width arithmetic: compute unsigned at full width. The maximum is 27000 + 255*106 = 54030, which fits in 17 bits. Any overflow beyond `WIDTH_W` saturates to all-ones.
- Timeout: an inter-byte counter runs in `P_POS` and `P_CHK` and clears on each `rx_valid`.
  - Reaching `TIMEOUT_CYC` with no `rx_valid` that cycle returns the parser to `P_IDLE` and pulses `frame_err`. No response is queued.
  - If `rx_valid` arrives in the expiry cycle, the byte wins.
- `rx_break` high in `P_POS` or `P_CHK`: return to `P_IDLE`, pulse `frame_err`, no response. In `P_IDLE`, bytes are ignored while `rx_break` is high. If `rx_break` and `rx_valid` are high in the same cycle, break wins.
- Response queue: one entry (`pend` flag plus byte). A new response while `pend` is set overwrites the byte, so the last response wins. A response already handed to the TX FSM is never altered.
- TX FSM:
  - `T_IDLE`: when `pend` is set and `tx_busy` is low, load `tx_data`, pulse `tx_en`, clear `pend`, go to `T_HOLD`.
  - `T_HOLD`: ignore `tx_busy` for 2 cycles, then go to `T_WAIT`.
  - `T_WAIT`: wait for `tx_busy` low, then go to `T_IDLE`.

## Timing
- Reset values:
  - `tx_en`=0, `tx_data`=`ACK_BYTE`, `pwm_update`=0, `frame_ok`=0, `frame_err`=0.
  - `pwm_width` = `PW_MIN_CYC + 128*PW_STEP_CYC` (40568, servo centre).
  - FSMs in `P_IDLE` and `T_IDLE`; `pend`=0; timeout counter=0.
- Reset mid-frame or mid-transmit: all state returns to reset values immediately (asynchronous). Any pending response is dropped.
- `CHK` byte with `rx_valid` at cycle N:
  - `pwm_width`, `pwm_update`, `frame_ok`/`frame_err` and `pend` all update at N+1.
  - `tx_en` rises no earlier than N+2, on the first cycle with `tx_busy` low in `T_IDLE`.
- Back-to-back `rx_valid` strobes on consecutive cycles are accepted; the parser processes one byte per cycle.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset release -> `pwm_width`=40568, `tx_en`=0 for 100 cycles with idle inputs.
- Bytes 55, 00, FF -> `pwm_width`=27000 with a one-cycle `pwm_update` and `frame_ok`; `tx_en` pulses with `tx_data`=06. Then bytes 55, FF, 00 -> `pwm_width`=54030.
- Bytes 55, 10, 10 -> `frame_err` pulse, `pwm_width` unchanged, `tx_data`=15.
- Bytes 55, 40, then no byte for `TIMEOUT_CYC` cycles -> `frame_err`, parser idle, no `tx_en`. Then 55, 40, BF -> `pwm_width`=33784.
- Two valid frames while `tx_busy` is held high -> exactly one response is queued, and it is the second frame's byte. It is sent after `tx_busy` falls; the total `tx_en` count is 2 when the first response was already in flight.
- `rx_break` asserted after `POS`, with `rx_valid` in the same cycle as the break -> `frame_err`, no width change. Assert `resetn`=0 during `T_WAIT` -> outputs return to reset values asynchronously.
